// File: rtl/button_bounce_gen.sv
// Contact-bounce emulator: each time the clean target level changes, it drives
// a burst of pseudo-random glitches on 'noisy'. The output then holds the new
// level for a fixed settle time before the block accepts the next change.
module button_bounce_gen #(
    parameter int          BOUNCES    = 3,        // glitch pairs per transition (0..15)
    parameter int          DWELL_W    = 4,        // dwell field width, dwell = 1..2^DWELL_W
    parameter int          SETTLE_CYC = 32,       // stable hold after the burst (>=1)
    parameter logic [15:0] SEED       = 16'hACE1  // LFSR reset value
) (
    input  logic clk,
    input  logic reset_n,
    input  logic level,
    output logic noisy,
    output logic busy,
    output logic done
);

    // Counter widths. settle_reg is loaded with SETTLE_CYC-1 and counts down to
    // zero, so it never needs to hold SETTLE_CYC itself.
    localparam int             SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [4:0]     LAST_TOG    = 5'(2 * BOUNCES);
    localparam logic [SW-1:0]  SETTLE_LOAD = SW'(SETTLE_CYC - 1);
    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0]    SEED_FIX    = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t             state_reg;
    logic [15:0]        lfsr_reg;
    logic [15:0]        lfsr_next;
    logic [DWELL_W-1:0] dwell_reg;   // remaining dwell minus one
    logic [4:0]         toggle_reg;  // toggles made so far in this burst
    logic [SW-1:0]      settle_reg;  // remaining settle cycles minus one
    logic               target_reg;
    logic               noisy_reg;
    logic               busy_reg;
    logic               done_reg;

    // Next LFSR value: 16-bit Fibonacci, taps 16,14,13,11, shift left, feedback into bit 0.
    assign lfsr_next = {lfsr_reg[14:0],
                        lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

    assign noisy = noisy_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;

    // Burst sequencer. A dwell of D cycles is held by loading D-1 (the LFSR
    // low bits) and toggling on the cycle the counter is already zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            lfsr_reg   <= SEED_FIX;
            dwell_reg  <= '0;
            toggle_reg <= '0;
            settle_reg <= '0;
            target_reg <= 1'b0;
            noisy_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (level != noisy_reg) begin
                        noisy_reg  <= ~noisy_reg;
                        target_reg <= level;
                        busy_reg   <= 1'b1;
                        if (BOUNCES == 0) begin
                            state_reg  <= SETTLE;
                            settle_reg <= SETTLE_LOAD;
                        end else begin
                            state_reg  <= BOUNCE;
                            toggle_reg <= 5'd1;
                            lfsr_reg   <= lfsr_next;
                            dwell_reg  <= lfsr_next[DWELL_W-1:0];
                        end
                    end
                end

                BOUNCE: begin
                    if (dwell_reg != '0) begin
                        dwell_reg <= dwell_reg - DWELL_W'(1);
                    end else begin
                        noisy_reg <= ~noisy_reg;
                        if (toggle_reg == LAST_TOG) begin
                            // Final toggle lands on target; no further dwell is drawn.
                            state_reg  <= SETTLE;
                            settle_reg <= SETTLE_LOAD;
                            toggle_reg <= '0;
                        end else begin
                            toggle_reg <= toggle_reg + 5'd1;
                            lfsr_reg   <= lfsr_next;
                            dwell_reg  <= lfsr_next[DWELL_W-1:0];
                        end
                    end
                end

                SETTLE: begin
                    noisy_reg <= target_reg;
                    if (settle_reg == '0) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        settle_reg <= settle_reg - SW'(1);
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_bounce_gen.sv
// Bench for button_bounce_gen. Three instances (default, no-bounce, zero seed)
// run against a burst-schedule model: on each burst start the model draws all
// dwells up front and derives the toggle edges and the end edge arithmetically.
module tb_button_bounce_gen;

    localparam int          NI        = 3;
    localparam int          PB [NI]   = '{3, 0, 2};
    localparam int          PS [NI]   = '{32, 4, 3};
    localparam logic [15:0] MSEED[NI] = '{16'hACE1, 16'h0001, 16'h0001};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic lvl [NI];
    logic rstn[NI];
    logic nz  [NI];
    logic bz  [NI];
    logic dn  [NI];

    button_bounce_gen #(.BOUNCES(3), .DWELL_W(4), .SETTLE_CYC(32), .SEED(16'hACE1)) dut_def (
        .clk(clk), .reset_n(rstn[0]), .level(lvl[0]), .noisy(nz[0]), .busy(bz[0]), .done(dn[0]));
    button_bounce_gen #(.BOUNCES(0), .DWELL_W(4), .SETTLE_CYC(4), .SEED(16'hACE1)) dut_nob (
        .clk(clk), .reset_n(rstn[1]), .level(lvl[1]), .noisy(nz[1]), .busy(bz[1]), .done(dn[1]));
    button_bounce_gen #(.BOUNCES(2), .DWELL_W(4), .SETTLE_CYC(3), .SEED(16'h0000)) dut_s0 (
        .clk(clk), .reset_n(rstn[2]), .level(lvl[2]), .noisy(nz[2]), .busy(bz[2]), .done(dn[2]));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model state per instance
    int          m_noisy[NI];
    int          m_busy [NI];
    int          m_done [NI];
    int          m_next [NI];
    int          m_end  [NI];
    int          m_ptr  [NI];
    int          m_len  [NI];
    bit [15:0]   m_lfsr [NI];
    int          m_dw   [NI][32];

    // Observed burst statistics per instance
    int          obs_tog [NI];
    int          obs_busy[NI];
    logic        prev_nz [NI];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit [15:0] lstep(input bit [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    // Advance the model of instance i across one rising edge.
    task automatic model_edge(input int i);
        int sum;
        if (!rstn[i]) begin
            m_noisy[i] = 0;
            m_busy[i]  = 0;
            m_done[i]  = 0;
            m_lfsr[i]  = MSEED[i];
        end else begin
            m_done[i] = 0;
            if (m_busy[i] != 0) begin
                if (cyc == m_end[i]) begin
                    m_busy[i] = 0;
                    m_done[i] = 1;
                end else if (cyc == m_next[i]) begin
                    m_noisy[i] ^= 1;
                    m_ptr[i]++;
                    if (m_ptr[i] < 2 * PB[i]) m_next[i] += m_dw[i][m_ptr[i]];
                    else                      m_next[i] = -1;
                end
            end else if (int'(lvl[i]) != m_noisy[i]) begin
                m_noisy[i] ^= 1;
                m_busy[i] = 1;
                sum = 0;
                for (int j = 0; j < 2 * PB[i]; j++) begin
                    m_lfsr[i] = lstep(m_lfsr[i]);
                    m_dw[i][j] = 1 + int'(m_lfsr[i] & 16'h000F);
                    sum += m_dw[i][j];
                end
                m_ptr[i]  = 0;
                m_next[i] = (PB[i] > 0) ? cyc + m_dw[i][0] : -1;
                m_len[i]  = sum + PS[i];
                m_end[i]  = cyc + m_len[i];
                $display("inst %0d: burst start cycle %0d target %0d busy_len %0d", i, cyc, m_noisy[i], m_len[i]);
            end
        end
    endtask

    // One clock: update models at the edge, then compare outputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) model_edge(i);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("noisy%0d", i), nz[i], m_noisy[i]);
            chk($sformatf("busy%0d", i),  bz[i], m_busy[i]);
            chk($sformatf("done%0d", i),  dn[i], m_done[i]);
            if (!rstn[i]) begin
                obs_tog[i]  = 0;
                obs_busy[i] = 0;
            end else begin
                if (nz[i] !== prev_nz[i]) obs_tog[i]++;
                if (bz[i] === 1'b1) obs_busy[i]++;
                if (dn[i] === 1'b1) begin
                    chk($sformatf("toggles%0d", i),  obs_tog[i],  2 * PB[i] + 1);
                    chk($sformatf("busylen%0d", i), obs_busy[i], m_len[i]);
                    obs_tog[i]  = 0;
                    obs_busy[i] = 0;
                end
            end
            prev_nz[i] = nz[i];
        end
    endtask

    task automatic run_until_done(input int i, input int budget);
        int n;
        n = 0;
        step();
        n++;
        while (dn[i] !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk($sformatf("done%0d_reached", i), dn[i], 1);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            lvl[i] = 1'b0; rstn[i] = 1'b0;
            m_noisy[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_next[i] = -1;
            m_end[i] = -1; m_ptr[i] = 0; m_len[i] = 0; m_lfsr[i] = MSEED[i];
            obs_tog[i] = 0; obs_busy[i] = 0; prev_nz[i] = 1'b0;
        end
        repeat (3) step();
        for (int i = 0; i < NI; i++) rstn[i] = 1'b1;
        repeat (2) step();

        // No-bounce instance: single toggle, busy for exactly 4 cycles.
        lvl[1] = 1'b1;
        run_until_done(1, 50);

        // Default instance: 7 toggles; a level wiggle mid-burst is ignored.
        lvl[0] = 1'b1;
        repeat (3) step();
        lvl[0] = 1'b0;
        repeat (2) step();
        lvl[0] = 1'b1;
        run_until_done(0, 400);
        repeat (5) step();
        chk("no_restart0", bz[0], 0);

        // Level changes again during the burst and is held: restart on the done cycle.
        lvl[0] = 1'b0;
        repeat (2) step();
        lvl[0] = 1'b1;
        run_until_done(0, 400);
        step();
        chk("restart0", bz[0], 1);
        run_until_done(0, 400);

        // Reset mid-BOUNCE, then release with level high: burst replays from SEED.
        lvl[0] = 1'b0;
        repeat (4) step();
        rstn[0] = 1'b0;
        step();
        rstn[0] = 1'b1;
        lvl[0]  = 1'b1;
        run_until_done(0, 400);

        // Randomized level activity and occasional resets on all instances.
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < NI; i++) begin
                if ($urandom_range(0, 39) == 0) lvl[i] = ~lvl[i];
                rstn[i] = ($urandom_range(0, 499) != 0);
            end
            step();
        end
        for (int i = 0; i < NI; i++) rstn[i] = 1'b1;
        repeat (200) step();
        for (int i = 0; i < NI; i++) chk($sformatf("idle_end%0d", i), bz[i], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
